// File: rtl/sevenseg_pkg.sv
// Shared constants for the seven-segment capture path: segment patterns,
// segment bit positions, the illegal-pattern nibble and the capture FSM states.
package sevenseg_pkg;

    // Segment bit positions inside a 7-bit pattern (a is the MSB).
    localparam int SEG_BIT_A = 6;
    localparam int SEG_BIT_B = 5;
    localparam int SEG_BIT_C = 4;
    localparam int SEG_BIT_D = 3;
    localparam int SEG_BIT_E = 2;
    localparam int SEG_BIT_F = 1;
    localparam int SEG_BIT_G = 0;

    // Patterns produced by the display driver for each hex value.
    localparam logic [6:0] SEG_0     = 7'h7E;
    localparam logic [6:0] SEG_1     = 7'h30;
    localparam logic [6:0] SEG_2     = 7'h6D;
    localparam logic [6:0] SEG_3     = 7'h79;
    localparam logic [6:0] SEG_4     = 7'h33;
    localparam logic [6:0] SEG_5     = 7'h5B;
    localparam logic [6:0] SEG_6     = 7'h5F;
    localparam logic [6:0] SEG_7     = 7'h70;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h7B;
    localparam logic [6:0] SEG_A     = 7'h04;
    // B shares its pattern with 1, so it can never be told apart on readback.
    localparam logic [6:0] SEG_B     = 7'h30;
    localparam logic [6:0] SEG_C     = 7'h58;
    localparam logic [6:0] SEG_D     = 7'h21;
    localparam logic [6:0] SEG_E     = 7'h18;
    localparam logic [6:0] SEG_F     = 7'h0E;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    // Nibble reported for any pattern that is not in the table.
    localparam logic [3:0] ILLEGAL = 4'h0;

    typedef enum logic [1:0] {
        S_WAIT  = 2'd0,
        S_COUNT = 2'd1,
        S_HELD  = 2'd2
    } cap_state_t;

endpackage

// File: rtl/sevenseg_dec.sv
// Combinational pattern-to-nibble decoder. Pattern 7'h30 always maps to 1;
// anything outside the table (blank included) is flagged illegal.
module sevenseg_dec
    import sevenseg_pkg::*;
(
    input  logic [6:0] i_seg,
    output logic       o_illegal,
    output logic [3:0] o_nib
);

    // Table lookup; default arm covers every illegal pattern.
    always_comb begin
        o_illegal = 1'b0;
        o_nib     = ILLEGAL;
        case (i_seg)
            SEG_0:   o_nib = 4'h0;
            SEG_1:   o_nib = 4'h1;
            SEG_2:   o_nib = 4'h2;
            SEG_3:   o_nib = 4'h3;
            SEG_4:   o_nib = 4'h4;
            SEG_5:   o_nib = 4'h5;
            SEG_6:   o_nib = 4'h6;
            SEG_7:   o_nib = 4'h7;
            SEG_8:   o_nib = 4'h8;
            SEG_9:   o_nib = 4'h9;
            SEG_A:   o_nib = 4'hA;
            SEG_C:   o_nib = 4'hC;
            SEG_D:   o_nib = 4'hD;
            SEG_E:   o_nib = 4'hE;
            SEG_F:   o_nib = 4'hF;
            default: begin
                o_illegal = 1'b1;
                o_nib     = ILLEGAL;
            end
        endcase
    end

endmodule

// File: rtl/sevenseg_capture.sv
// Captures stable digits from a multiplexed seven-segment bus, assembles them
// into a frame and offers the frame on a valid/ready handshake.
module sevenseg_capture
    import sevenseg_pkg::*;
#(
    parameter int NDIG   = 4,
    parameter int STABLE = 4
)(
    input  logic                clk,
    input  logic                rst,
    input  logic [6:0]          seg_in,
    input  logic [NDIG-1:0]     an_in,
    output logic [4*NDIG-1:0]   val_out,
    output logic                val_err,
    output logic                val_valid,
    input  logic                val_ready,
    output logic                overrun
);

    localparam int IDXW = (NDIG > 1) ? $clog2(NDIG) : 1;

    logic [6:0]        r_seg;
    logic [NDIG-1:0]   r_an;
    cap_state_t        r_state;
    cap_state_t        w_state_nxt;
    logic [7:0]        r_cnt;
    logic [7:0]        w_cnt_nxt;
    logic              w_write;
    logic              w_onehot;
    logic              w_same;
    logic              w_full;
    logic [IDXW-1:0]   w_idx;
    logic [3:0]        w_dec_nib;
    logic              w_dec_ill;
    logic [4*NDIG-1:0] r_nib;
    logic [NDIG-1:0]   r_errs;
    logic [NDIG-1:0]   r_mask;
    logic [NDIG-1:0]   w_mask_nxt;
    logic [NDIG-1:0]   w_errs_nxt;

    // The registered copy equals the live input whenever a write fires.
    sevenseg_dec u_dec (
        .i_seg     (r_seg),
        .o_illegal (w_dec_ill),
        .o_nib     (w_dec_nib)
    );

    assign w_onehot = (an_in != '0) && ((an_in & (an_in - 1'b1)) == '0);
    assign w_same   = w_onehot && (seg_in == r_seg) && (an_in == r_an);
    assign w_full   = &r_mask;

    // Binary index of the strobed digit.
    always_comb begin
        w_idx = '0;
        for (int i = 0; i < NDIG; i++) begin
            if (r_an[i]) begin
                w_idx = IDXW'(i);
            end else begin
                w_idx = w_idx;
            end
        end
    end

    // Capture FSM next state: count equal samples, write once per stable dwell.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_write     = 1'b0;
        case (r_state)
            S_WAIT: begin
                if (w_same) begin
                    w_state_nxt = S_COUNT;
                    w_cnt_nxt   = 8'd1;
                end else begin
                    w_state_nxt = S_WAIT;
                    w_cnt_nxt   = 8'd0;
                end
            end
            S_COUNT: begin
                if (!w_same) begin
                    w_state_nxt = S_WAIT;
                    w_cnt_nxt   = 8'd0;
                end else if (r_cnt == 8'(STABLE - 1)) begin
                    w_state_nxt = S_HELD;
                    w_cnt_nxt   = 8'd0;
                    w_write     = 1'b1;
                end else begin
                    w_cnt_nxt   = r_cnt + 8'd1;
                end
            end
            S_HELD: begin
                if (!w_same) begin
                    w_state_nxt = S_WAIT;
                end else begin
                    w_state_nxt = S_HELD;
                end
                w_cnt_nxt = 8'd0;
            end
            default: begin
                w_state_nxt = S_WAIT;
                w_cnt_nxt   = 8'd0;
            end
        endcase
    end

    // Mask/err update: a completing frame clears them, a same-cycle write still lands.
    always_comb begin
        w_mask_nxt = w_full ? '0 : r_mask;
        w_errs_nxt = w_full ? '0 : r_errs;
        if (w_write) begin
            w_mask_nxt[w_idx] = 1'b1;
            w_errs_nxt[w_idx] = w_dec_ill;
        end else begin
            w_mask_nxt = w_mask_nxt;
            w_errs_nxt = w_errs_nxt;
        end
    end

    // Input registers, FSM state and the per-digit nibble store.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_seg   <= 7'h00;
            r_an    <= '0;
            r_state <= S_WAIT;
            r_cnt   <= 8'd0;
            r_nib   <= '0;
            r_errs  <= '0;
            r_mask  <= '0;
        end else begin
            r_seg   <= seg_in;
            r_an    <= an_in;
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_errs  <= w_errs_nxt;
            r_mask  <= w_mask_nxt;
            if (w_write) begin
                r_nib[{w_idx, 2'b00} +: 4] <= w_dec_nib;
            end
        end
    end

    // Output frame register and handshake; completion wins over a transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            val_out   <= '0;
            val_err   <= 1'b0;
            val_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            overrun <= w_full & val_valid & ~val_ready;
            if (w_full) begin
                val_out   <= r_nib;
                val_err   <= |r_errs;
                val_valid <= 1'b1;
            end else if (val_valid && val_ready) begin
                val_valid <= 1'b0;
            end
        end
    end

endmodule
